// File: rtl/uwasic_onboarding_vishnu_ajit.sv
// SPI write-only register file (mode 0, 16-bit frames) driving 16 output
// channels, each either off, statically on, or gated by a shared 8-bit PWM.
module uwasic_onboarding_vishnu_ajit #(
    parameter int PRESCALE    = 13,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [SYNC_STAGES-1:0] sclk_sh, copi_sh, ncs_sh;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_d, ncs_d;
    logic                   sclk_rise, ncs_fall, ncs_rise;

    logic [15:0] shreg;
    logic [4:0]  bit_cnt;
    logic        commit;

    logic [15:0] en_out, en_pwm;
    logic [7:0]  duty;

    logic [PW-1:0] pre;
    logic [7:0]    pwm_cnt;
    logic          pwm;
    logic [15:0]   ch;

    logic unused;
    assign unused = &{1'b0, ena, uio_in, ui_in[7:3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sh <= '0;
            copi_sh <= '0;
            ncs_sh  <= '0;
            sclk_d  <= 1'b0;
            ncs_d   <= 1'b0;
        end else begin
            sclk_sh[0] <= ui_in[0];
            copi_sh[0] <= ui_in[1];
            ncs_sh[0]  <= ui_in[2];
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sh[i] <= sclk_sh[i-1];
                copi_sh[i] <= copi_sh[i-1];
                ncs_sh[i]  <= ncs_sh[i-1];
            end
            sclk_d <= sclk_s;
            ncs_d  <= ncs_s;
        end
    end

    assign sclk_s    = sclk_sh[SYNC_STAGES-1];
    assign copi_s    = copi_sh[SYNC_STAGES-1];
    assign ncs_s     = ncs_sh[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign ncs_fall  = ~ncs_s & ncs_d;
    assign ncs_rise  = ncs_s & ~ncs_d;

    // Bit counter saturates at 17 so overlong frames can never alias to 16.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (ncs_fall) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (!ncs_s && sclk_rise) begin
            shreg   <= {shreg[14:0], copi_s};
            bit_cnt <= (bit_cnt == 5'd17) ? 5'd17 : bit_cnt + 5'd1;
        end
    end

    assign commit = ncs_rise && (bit_cnt == 5'd16) && shreg[15] && (shreg[14:8] <= 7'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            en_out <= '0;
            en_pwm <= '0;
            duty   <= '0;
        end else if (commit) begin
            case (shreg[14:8])
                7'd0:    en_out[7:0]  <= shreg[7:0];
                7'd1:    en_out[15:8] <= shreg[7:0];
                7'd2:    en_pwm[7:0]  <= shreg[7:0];
                7'd3:    en_pwm[15:8] <= shreg[7:0];
                7'd4:    duty         <= shreg[7:0];
                default: ;
            endcase
        end
    end

    // Free-running PWM timebase; register writes never realign it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre     <= '0;
            pwm_cnt <= '0;
        end else if (pre == PW'(PRESCALE - 1)) begin
            pre     <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    assign pwm = (duty == 8'hFF) || (pwm_cnt < duty);

    assign ch      = en_out & (~en_pwm | {16{pwm}});
    assign uo_out  = ch[7:0];
    assign uio_out = ch[15:8];
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_uwasic_onboarding_vishnu_ajit.sv
// Scoreboarded bench: SPI frames update a register model whose expected
// outputs are queued and compared once the write has settled.
module tb_uwasic_onboarding_vishnu_ajit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic [7:0] uio_in = 8'h00;

    always #50 clk = ~clk;

    uwasic_onboarding_vishnu_ajit dut (
        .clk(clk), .rst(rst), .ena(ena),
        .ui_in({5'b0, ncs, copi, sclk}),
        .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    typedef struct {
        string       tag;
        logic [15:0] exp;
        logic [15:0] mask;
    } sb_t;

    sb_t         q[$];
    int          n_chk = 0, n_err = 0;
    logic [15:0] m_en_out = '0, m_en_pwm = '0;
    logic [7:0]  m_duty = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        copi = b;
        clks(4);
        sclk = 1'b1;
        clks(4);
        sclk = 1'b0;
    endtask

    // Sends bits[nbits-1:0] MSB first and applies the frame to the model.
    task automatic spi_send(input logic [16:0] bits, input int nbits);
        ncs = 1'b0;
        clks(4);
        for (int i = nbits - 1; i >= 0; i--) send_bit(bits[i]);
        clks(4);
        ncs = 1'b1;
        clks(4);
        if (nbits == 16 && bits[15] && bits[14:8] <= 7'd4) begin
            case (bits[10:8])
                3'd0: m_en_out[7:0]  = bits[7:0];
                3'd1: m_en_out[15:8] = bits[7:0];
                3'd2: m_en_pwm[7:0]  = bits[7:0];
                3'd3: m_en_pwm[15:8] = bits[7:0];
                default: m_duty      = bits[7:0];
            endcase
        end
    endtask

    task automatic wr(input logic [6:0] addr, input logic [7:0] data);
        spi_send({1'b0, 1'b1, addr, data}, 16);
    endtask

    // PWM-driven channels are masked; they are checked by the timing tasks.
    task automatic sb_push(input string tag);
        sb_t e;
        e.tag  = tag;
        e.mask = m_en_out & m_en_pwm;
        e.exp  = m_en_out & ~m_en_pwm;
        q.push_back(e);
    endtask

    task automatic sb_check();
        sb_t e;
        clks(5);
        while (q.size() > 0) begin
            e = q.pop_front();
            chk(e.tag, {uio_out, uo_out} & ~e.mask, e.exp & ~e.mask);
        end
    endtask

    task automatic pwm_measure(input string tag, output int hi, output int per);
        logic prev;
        int   t, lo;
        hi = 0;
        lo = 0;
        t  = 0;
        prev = uo_out[0];
        clks(1);
        while (!(!prev && uo_out[0]) && t < 8000) begin
            prev = uo_out[0];
            clks(1);
            t++;
        end
        if (t >= 8000) chk({tag, "_rise_timeout"}, 32'd0, 32'd1);
        while (uo_out[0] && hi < 8000) begin
            hi++;
            clks(1);
        end
        while (!uo_out[0] && lo < 8000) begin
            lo++;
            clks(1);
        end
        per = hi + lo;
    endtask

    int hi, per, cnt, bad;

    initial begin
        @(posedge clk);
        #1;
        chk("rst_first_edge", {16'h0, uio_out, uo_out}, 32'h0);
        clks(5);
        chk("rst_uio_oe", uio_oe, 8'hFF);
        chk("rst_outputs", {uio_out, uo_out}, 16'h0);
        rst = 1'b0;
        clks(20);
        chk("idle_outputs", {uio_out, uo_out}, 16'h0);
        chk("idle_uio_oe", uio_oe, 8'hFF);

        wr(7'h00, 8'hF0);
        sb_push("static_lo");
        sb_check();
        wr(7'h01, 8'hCC);
        sb_push("static_hi");
        sb_check();

        spi_send({1'b0, 1'b0, 7'h00, 8'hFF}, 16);
        sb_push("read_frame");
        sb_check();
        wr(7'h30, 8'h0F);
        sb_push("bad_addr_30");
        sb_check();
        wr(7'h05, 8'hFF);
        sb_push("bad_addr_05");
        sb_check();
        spi_send({2'b0, 15'h4007}, 15);
        sb_push("short_frame");
        sb_check();
        spi_send({1'b1, 16'h800F}, 17);
        sb_push("long_frame");
        sb_check();

        wr(7'h00, 8'h01);
        wr(7'h02, 8'h01);
        wr(7'h04, 8'h80);
        sb_push("back_to_back");
        sb_check();

        pwm_measure("pwm80", hi, per);
        chk("pwm80_high", hi, 32'd1664);
        chk("pwm80_period", per, 32'd3328);

        wr(7'h04, 8'h01);
        pwm_measure("pwm01", hi, per);
        chk("pwm01_high", hi, 32'd13);
        chk("pwm01_period", per, 32'd3328);

        wr(7'h04, 8'h00);
        clks(5);
        cnt = 0;
        for (int i = 0; i < 6656; i++) begin
            clks(1);
            if (uo_out[0]) cnt++;
        end
        chk("duty00_highs", cnt, 32'd0);

        wr(7'h04, 8'hFF);
        clks(5);
        cnt = 0;
        for (int i = 0; i < 6656; i++) begin
            clks(1);
            if (!uo_out[0]) cnt++;
        end
        chk("dutyFF_lows", cnt, 32'd0);

        wr(7'h01, 8'h00);
        wr(7'h03, 8'hFF);
        sb_push("prio_pwm_only");
        sb_check();
        wr(7'h04, 8'h80);
        wr(7'h01, 8'h0F);
        sb_push("prio_upper_off");
        sb_check();
        cnt = 0;
        bad = 0;
        for (int i = 0; i < 3328; i++) begin
            clks(1);
            if (uio_out[3:0] == 4'hF) cnt++;
            else if (uio_out[3:0] != 4'h0) bad++;
            if (uio_out[7:4] != 4'h0) bad++;
        end
        chk("prio_high_count", cnt, 32'd1664);
        chk("prio_glitches", bad, 32'd0);

        // Reset in the middle of a valid write must leave everything cleared.
        ncs = 1'b0;
        clks(4);
        for (int i = 15; i >= 6; i--) send_bit(16'h80AA >> i);
        rst = 1'b1;
        clks(3);
        rst = 1'b0;
        for (int i = 5; i >= 0; i--) send_bit(16'h80AA >> i);
        clks(4);
        ncs = 1'b1;
        clks(4);
        m_en_out = '0;
        m_en_pwm = '0;
        m_duty   = '0;
        sb_push("rst_mid_frame");
        sb_check();
        chk("rst_mid_uio_oe", uio_oe, 8'hFF);

        wr(7'h00, 8'h5A);
        sb_push("post_rst_write");
        sb_check();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uwasic_onboarding_vishnu_ajit.md
Name: uwasic_onboarding_vishnu_ajit

Overview:
Tiny Tapeout user block: an SPI write-only register peripheral drives a 16-channel output controller with a shared PWM generator. An external SPI controller (mode 0) writes enable, PWM-enable and duty-cycle registers. Channels 0-7 drive uo_out and channels 8-15 drive uio_out. Targets a 10 MHz system clock, giving roughly 3 kHz PWM.

Parameters:
PRESCALE, 13, system clocks per PWM counter step; PWM period = PRESCALE*256 clk (3004.8 Hz at 10 MHz)
SYNC_STAGES, 2, flip-flop stages on each SPI input synchronizer

Ports:
clk  input  1  system clock (10 MHz nominal), all logic on rising edge
rst  input  1  synchronous, active-high reset
ena  input  1  design-selected flag; ignored
ui_in  input  8  [0]=SCLK, [1]=COPI, [2]=nCS (active low); [7:3] unused
uo_out  output  8  channel outputs 7..0
uio_in  input  8  unused
uio_out  output  8  channel outputs 15..8
uio_oe  output  8  constant 8'hFF (all bidirectional pins are outputs)

Behaviour:
- Registers, all 8 bits, reset 0x00: 0x00 en_out[7:0]; 0x01 en_out[15:8]; 0x02 en_pwm[7:0]; 0x03 en_pwm[15:8]; 0x04 duty.
- SCLK, COPI and nCS each pass through a SYNC_STAGES flop synchronizer into the clk domain. Edges are detected on the synchronized values, using one extra delay flop per signal.
- Transaction starts on the nCS falling edge: bit counter and shift register clear.
- While nCS is low, each SCLK rising edge shifts COPI in MSB-first and increments the bit counter. The counter saturates at 17, meaning "too many bits".
- Frame format, 16 bits: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- Commit happens on the nCS rising edge, and only if all of these hold: count == 16, R/W == 1, address <= 0x04. The addressed register takes the data within SYNC_STAGES+2 clk of nCS going high.
- Discarded without any effect: reads (R/W = 0), addresses 0x05..0x7F, frames shorter or longer than 16 bits.
- SCLK edges while nCS is high are ignored.
- PWM prescaler counts 0..PRESCALE-1. On wrap, an 8-bit counter increments and wraps 255 -> 0.
- pwm = 1 if duty == 0xFF; otherwise pwm = (counter < duty).
  - duty 0x00 gives a constant 0.
  - duty 0x80 gives 50 % high (128 of 256 steps).
- The PWM counters free-run and are not reset by register writes. A duty change takes effect immediately (no period alignment).
- Channel i output = en_out[i] ? (en_pwm[i] ? pwm : 1) : 0. en_out takes priority: en_pwm without en_out gives 0.
- Outputs are combinational from registers and pwm. uo_out = ch[7:0], uio_out = ch[15:8].
- Reset:
  - Registers, counters, synchronizers and SPI state clear to 0.
  - uo_out and uio_out read 0x00 on the first clk edge with rst high.
  - uio_oe stays 0xFF.
  - Reset asserted mid-transaction aborts the frame; no write occurs.
- A new transaction can start immediately after commit. Back-to-back frames each commit independently.

Test Plan:
- Reset: rst high 5 clk -> uo_out=0x00, uio_out=0x00, uio_oe=0xFF; after release, outputs stay 0x00 with no SPI activity.
- Static enable: write 0x00<=0xF0, 0x01<=0xCC -> uo_out=0xF0, uio_out=0xCC within 5 clk of nCS high.
- Invalid writes:
  - read frame (bit15=0) to 0x00 with data 0xFF -> no change.
  - write to 0x30 -> no change.
  - 15-bit frame to 0x00 -> uo_out unchanged.
  - 17-bit frame to 0x00 -> uo_out unchanged.
- PWM frequency/duty: en_out[0]=1, en_pwm[0]=1, duty=0x80 -> uo_out[0] period 3328 clk (3004.8 Hz ±1 %), high 1664 clk (50 %).
- Duty extremes:
  - duty=0x00 -> uo_out[0] constant 0 over 2 periods.
  - duty=0xFF -> uo_out[0] constant 1 over 2 periods.
- Priority: en_pwm[15:8]=0xFF with en_out[15:8]=0x00 -> uio_out=0x00; then en_out[15:8]=0x0F -> uio_out[3:0] toggle at PWM, uio_out[7:4]=0.
